// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL register window,
// a small TX FIFO and an 8N1 serializer with a programmable bit period.
module uart_tx_mmio #(
  parameter logic [31:0] BASE   = 32'h0000_0400,
  parameter int          DIVRST = 16,
  parameter int          DEPTH  = 8
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [3:0]  BE,
  input  logic        WR,
  input  logic        RD,
  output logic [31:0] DATAI,
  output logic        TXD,
  output logic        IRQ
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          ovf_q;
  logic [15:0]   div_q;
  logic          irqEn_q;
  logic [31:0]   datai_q;

  logic        sel, selTx, selStatus, selCtrl;
  logic        push, pushOk, pop;
  logic        fifoFull, fifoEmpty, busy;
  logic [15:0] divEff, reload;
  logic [4:0]  count5;
  logic [31:0] statusWord, rdata;
  logic        unused;

  assign sel       = (DADDR[31:4] == BASE[31:4]) && (DADDR[3:2] != 2'd3);
  assign selTx     = sel && (DADDR[3:2] == 2'd0);
  assign selStatus = sel && (DADDR[3:2] == 2'd1);
  assign selCtrl   = sel && (DADDR[3:2] == 2'd2);

  assign fifoFull  = (count_q == CW'(DEPTH));
  assign fifoEmpty = (count_q == '0);
  assign busy      = (state_q != IDLE);

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign push   = WR && selTx && BE[0];
  assign pushOk = push && (!fifoFull || pop);

  assign divEff = (div_q < 16'd2) ? 16'd2 : div_q;
  assign reload = divEff - 16'd1;

  assign count5     = 5'(count_q);
  assign statusWord = {23'd0, count5, ovf_q, busy, fifoEmpty, fifoFull};

  always_comb begin
    rdata = 32'd0;
    case (DADDR[3:2])
      2'd1:    rdata = statusWord;
      2'd2:    rdata = {15'd0, irqEn_q, div_q};
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = mem_q[rdPtr_q];
          cnt_d   = reload;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d    = reload;
          bitIdx_d = 3'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d = reload;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = mem_q[rdPtr_q];
          cnt_d   = reload;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({pushOk, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      bitIdx_q <= 3'd0;
      shift_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)    rdPtr_q <= rdPtr_q + AW'(1);
      if (push && fifoFull && !pop) begin
        ovf_q <= 1'b1;
      end else if (WR && selStatus && BE[0] && DATAO[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (pushOk) mem_q[wrPtr_q] <= DATAO[7:0];
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      div_q   <= 16'(DIVRST);
      irqEn_q <= 1'b0;
      datai_q <= 32'd0;
    end else begin
      if (WR && selCtrl) begin
        if (BE[0]) div_q[7:0]  <= DATAO[7:0];
        if (BE[1]) div_q[15:8] <= DATAO[15:8];
        if (BE[2]) irqEn_q     <= DATAO[16];
      end
      if (RD && sel) datai_q <= rdata;
    end
  end

  assign DATAI = datai_q;
  assign TXD   = (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? shift_q[0] : 1'b1;
  assign IRQ   = irqEn_q && fifoEmpty && !busy;

  assign unused = ^{DADDR[1:0], DATAO[31:17], BE[3]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register accesses with random
// payloads, line waveform predicted from the 8N1 frame rules.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESN = 1'b0;
  logic [31:0] DADDR = 32'd0;
  logic [31:0] DATAO = 32'd0;
  logic [3:0]  BE = 4'd0;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  logic [31:0] DATAI;
  logic        TXD;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  uart_tx_mmio #(.BASE(BASE), .DIVRST(16), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESN(RESN), .DADDR(DADDR), .DATAO(DATAO), .BE(BE),
    .WR(WR), .RD(RD), .DATAI(DATAI), .TXD(TXD), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] expStatus(int n, bit ovf, bit bsy);
    int v;
    v = (n << 4) + (ovf ? 8 : 0) + (bsy ? 4 : 0) + ((n == 0) ? 2 : 0) + ((n == DEPTH) ? 1 : 0);
    return 32'(v);
  endfunction

  // Line level t cycles into a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic lineAt(logic [7:0] b, int div, int t);
    int eff;
    int seg;
    eff = (div < 2) ? 2 : div;
    seg = t / eff;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input bit isWrite);
    @(negedge CLK);
    DADDR = addr;
    DATAO = data;
    BE    = be;
    WR    = isWrite;
    RD    = !isWrite;
    @(negedge CLK);
    WR = 1'b0;
    RD = 1'b0;
  endtask

  task automatic watchFrame(input logic [7:0] b, input int div, input bit irqOn, input string tag);
    int eff;
    eff = (div < 2) ? 2 : div;
    checkOutput({tag, "_irq_push"}, 32'(IRQ), 32'd0);
    for (int k = 0; k < 10 * eff; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("%s_txd_c%0d", tag, k), 32'(TXD), 32'(lineAt(b, div, k)));
      if (irqOn && (k == 10 * eff - 1)) checkOutput({tag, "_irq_stop"}, 32'(IRQ), 32'd0);
    end
    @(negedge CLK);
    checkOutput({tag, "_txd_idle"}, 32'(TXD), 32'd1);
    checkOutput({tag, "_irq_end"}, 32'(IRQ), 32'(irqOn));
    applyStimulus(BASE + 32'd4, 32'd0, 4'hF, 1'b0);
    checkOutput({tag, "_status_end"}, DATAI, expStatus(0, 1'b0, 1'b0));
  endtask

  task automatic checkFrame(input logic [7:0] b, input int div, input bit irqOn, input string tag);
    applyStimulus(BASE, {24'd0, b}, 4'b0001, 1'b1);
    watchFrame(b, div, irqOn, tag);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] burst [9];
    logic [7:0] model [$];
    bit         ovfModel;

    repeat (3) @(negedge CLK);
    checkOutput("reset_txd", 32'(TXD), 32'd1);
    checkOutput("reset_irq", 32'(IRQ), 32'd0);
    checkOutput("reset_datai", DATAI, 32'd0);
    RESN = 1'b1;

    applyStimulus(BASE + 32'd4, 32'd0, 4'hF, 1'b0);
    checkOutput("status_reset", DATAI, expStatus(0, 1'b0, 1'b0));
    applyStimulus(BASE + 32'd12, 32'd0, 4'hF, 1'b0);
    checkOutput("unmapped_read", DATAI, expStatus(0, 1'b0, 1'b0));
    applyStimulus(BASE + 32'd8, 32'd0, 4'hF, 1'b0);
    checkOutput("ctrl_reset", DATAI, 32'h0000_0010);
    applyStimulus(BASE, 32'd0, 4'hF, 1'b0);
    checkOutput("txdata_read", DATAI, 32'd0);

    applyStimulus(BASE + 32'h10, 32'h55, 4'hF, 1'b1);
    applyStimulus(BASE + 32'd12, 32'h55, 4'hF, 1'b1);
    applyStimulus(BASE + 32'd0, 32'h55, 4'b1110, 1'b1);
    applyStimulus(BASE + 32'd6, 32'd0, 4'hF, 1'b0);
    checkOutput("unselected_push", DATAI, expStatus(0, 1'b0, 1'b0));
    checkOutput("unselected_txd", 32'(TXD), 32'd1);

    $display("[TB] single frame 0xA5, DIV=16");
    checkFrame(8'hA5, 16, 1'b0, "a5");

    $display("[TB] interrupt on drain");
    applyStimulus(BASE + 32'd8, 32'h0001_0010, 4'b0111, 1'b1);
    checkOutput("irq_enabled_idle", 32'(IRQ), 32'd1);
    b = 8'($urandom);
    checkFrame(b, 16, 1'b1, "irq");
    applyStimulus(BASE + 32'd8, 32'd0, 4'b0100, 1'b1);
    checkOutput("irq_disabled", 32'(IRQ), 32'd0);
    applyStimulus(BASE + 32'd8, 32'd0, 4'hF, 1'b0);
    checkOutput("ctrl_irqen_off", DATAI, 32'h0000_0010);

    $display("[TB] small divisors");
    applyStimulus(BASE + 32'd8, 32'd0, 4'b0011, 1'b1);
    applyStimulus(BASE + 32'd8, 32'd0, 4'hF, 1'b0);
    checkOutput("ctrl_div0", DATAI, 32'd0);
    b = 8'($urandom);
    checkFrame(b, 0, 1'b0, "div0");
    applyStimulus(BASE + 32'd8, 32'd1, 4'b0011, 1'b1);
    b = 8'($urandom);
    checkFrame(b, 1, 1'b0, "div1");
    applyStimulus(BASE + 32'd8, 32'd3, 4'b0011, 1'b1);
    b = 8'($urandom);
    checkFrame(b, 3, 1'b0, "div3");
    applyStimulus(BASE + 32'd8, 32'd16, 4'b0011, 1'b1);

    $display("[TB] nine back-to-back pushes");
    foreach (burst[i]) burst[i] = 8'($urandom);
    for (int j = 0; j < 1442; j++) begin
      @(negedge CLK);
      if (j >= 2)
        checkOutput($sformatf("burst_txd_t%0d", j - 2), 32'(TXD),
                    32'(lineAt(burst[(j - 2) / 160], 16, (j - 2) % 160)));
      if (j < 9) begin
        DADDR = BASE;
        DATAO = {24'd0, burst[j]};
        BE    = 4'b0001;
        WR    = 1'b1;
      end else begin
        WR = 1'b0;
      end
    end
    applyStimulus(BASE + 32'd4, 32'd0, 4'hF, 1'b0);
    checkOutput("burst_status", DATAI, expStatus(0, 1'b0, 1'b0));

    $display("[TB] overflow while transmitter busy");
    model.delete();
    ovfModel = 1'b0;
    applyStimulus(BASE, 32'h0000_003C, 4'b0001, 1'b1);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      applyStimulus(BASE, {24'd0, b}, 4'b0001, 1'b1);
      if (model.size() < DEPTH) model.push_back(b);
      else ovfModel = 1'b1;
    end
    applyStimulus(BASE + 32'd4, 32'd0, 4'hF, 1'b0);
    checkOutput("ovf_status", DATAI, expStatus(model.size(), ovfModel, 1'b1));
    applyStimulus(BASE + 32'd4, 32'h8, 4'b0001, 1'b1);
    ovfModel = 1'b0;
    applyStimulus(BASE + 32'd4, 32'd0, 4'hF, 1'b0);
    checkOutput("ovf_cleared", DATAI, expStatus(model.size(), ovfModel, 1'b1));

    $display("[TB] reset with full FIFO, push on first edge after release");
    @(negedge CLK);
    RESN = 1'b0;
    #1;
    checkOutput("rst_full_txd", 32'(TXD), 32'd1);
    checkOutput("rst_full_datai", DATAI, 32'd0);
    @(negedge CLK);
    b = 8'($urandom);
    RESN  = 1'b1;
    DADDR = BASE;
    DATAO = {24'd0, b};
    BE    = 4'b0001;
    WR    = 1'b1;
    @(negedge CLK);
    WR = 1'b0;
    watchFrame(b, 16, 1'b0, "first_push");
    applyStimulus(BASE + 32'd8, 32'd0, 4'hF, 1'b0);
    checkOutput("ctrl_after_reset", DATAI, 32'h0000_0010);

    $display("[TB] reset during data bit 3");
    applyStimulus(BASE + 32'd8, 32'd4, 4'b0011, 1'b1);
    b = 8'($urandom) & 8'hF7;
    applyStimulus(BASE, {24'd0, b}, 4'b0001, 1'b1);
    for (int k = 0; k < 18; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("abort_txd_c%0d", k), 32'(TXD), 32'(lineAt(b, 4, k)));
    end
    RESN = 1'b0;
    #1;
    checkOutput("abort_txd_async", 32'(TXD), 32'd1);
    checkOutput("abort_irq", 32'(IRQ), 32'd0);
    checkOutput("abort_datai", DATAI, 32'd0);
    @(negedge CLK);
    RESN = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("abort_quiet_c%0d", k), 32'(TXD), 32'd1);
    end
    applyStimulus(BASE + 32'd4, 32'd0, 4'hF, 1'b0);
    checkOutput("abort_status", DATAI, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
